// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: drops CP_LEN prefix samples per symbol and forwards
// the N_FFT useful samples into a first-word-fall-through output FIFO.
module ofdm_cp_remover #(
    parameter int DATA_W     = 14,
    parameter int N_FFT      = 64,
    parameter int CP_LEN     = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          sync_start,
    input  logic                          clr_flags,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_real,
    input  logic [DATA_W-1:0]             in_imag,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_real,
    output logic [DATA_W-1:0]             out_imag,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [15:0]                   symbol_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          resync_err,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
    localparam int SW = (N_FFT > 1) ? $clog2(N_FFT) : 1;
    localparam int EW = 2 * DATA_W + 2;

    localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(N_FFT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP_CP = 2'd1,
        PASS    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cp_cnt_q, cp_cnt_d;
    logic [SW-1:0]   smp_cnt_q, smp_cnt_d;
    logic [15:0]     sym_cnt_q, sym_cnt_d;
    logic            ovf_q, ovf_d;
    logic            rse_q, rse_d;

    logic            start;
    logic            resync_hit;
    logic            push_req;
    logic            push_sop;
    logic            push_eop;

    // ------------------------------------------------------------------
    // Symbol framing
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cp_cnt_d   = cp_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        start      = 1'b0;
        resync_hit = 1'b0;
        push_req   = 1'b0;
        push_sop   = 1'b0;
        push_eop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && in_valid && sync_start) begin
                    start = 1'b1;
                end
            end
            SKIP_CP: begin
                // Dropping enable abandons the prefix in progress; no useful data lost.
                if (!en) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    if (sync_start) begin
                        start = 1'b1;
                    end else if (cp_cnt_q == CP_LAST) begin
                        state_d   = PASS;
                        smp_cnt_d = '0;
                    end else begin
                        cp_cnt_d = cp_cnt_q + CW'(1);
                    end
                end
            end
            PASS: begin
                if (in_valid) begin
                    if (sync_start) begin
                        resync_hit = 1'b1;
                        start      = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_sop = (smp_cnt_q == '0);
                        push_eop = (smp_cnt_q == SMP_LAST);
                        if (smp_cnt_q == SMP_LAST) begin
                            sym_cnt_d = sym_cnt_q + 16'd1;
                            smp_cnt_d = '0;
                            cp_cnt_d  = '0;
                            state_d   = en ? SKIP_CP : IDLE;
                        end else begin
                            smp_cnt_d = smp_cnt_q + SW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The sync sample itself is prefix sample 0, so counting resumes at 1.
        if (start) begin
            if (CP_LEN == 1) begin
                state_d   = PASS;
                smp_cnt_d = '0;
            end else begin
                state_d  = SKIP_CP;
                cp_cnt_d = CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through, no bypass)
    // ------------------------------------------------------------------
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [EW-1:0]   rd_word;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_FULL);
    assign pop     = !empty && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = push_req && (!full || pop);
    assign rd_word = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {push_sop, push_eop, in_real, in_imag};
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a new event in the same cycle overrides the clear.
    // ------------------------------------------------------------------
    always_comb begin
        ovf_d = ovf_q;
        rse_d = rse_q;
        if (clr_flags) begin
            ovf_d = 1'b0;
            rse_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (resync_hit) begin
            rse_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cp_cnt_q  <= '0;
            smp_cnt_q <= '0;
            sym_cnt_q <= '0;
            ovf_q     <= 1'b0;
            rse_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            cp_cnt_q  <= cp_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            ovf_q     <= ovf_d;
            rse_q     <= rse_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // Head-of-FIFO fields are masked while empty so stale RAM never shows.
    assign out_valid  = !empty;
    assign out_sop    = empty ? 1'b0 : rd_word[EW-1];
    assign out_eop    = empty ? 1'b0 : rd_word[EW-2];
    assign out_real   = empty ? '0 : rd_word[2*DATA_W-1:DATA_W];
    assign out_imag   = empty ? '0 : rd_word[DATA_W-1:0];
    assign symbol_cnt = sym_cnt_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign resync_err = rse_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Scoreboard bench for ofdm_cp_remover: a frame-position reference model predicts
// every output sample, FIFO level and flag; a negedge monitor checks them.
module tb_ofdm_cp_remover;

    localparam int DW = 14;
    localparam int NF = 64;
    localparam int CP = 16;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          sync_start = 1'b0;
    logic          clr_flags = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic          out_sop;
    logic          out_eop;
    logic [15:0]   symbol_cnt;
    logic [5:0]    fifo_level;
    logic          overflow;
    logic          resync_err;
    logic          busy;

    always #5 clk = ~clk;

    ofdm_cp_remover #(.DATA_W(DW), .N_FFT(NF), .CP_LEN(CP), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sync_start (sync_start),
        .clr_flags  (clr_flags),
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .symbol_cnt (symbol_cnt),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .resync_err (resync_err),
        .busy       (busy)
    );

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    // Reference model: m_pos is the index of the next sample inside a
    // CP+N_FFT frame (-1 while idle); m_lvl is the predicted FIFO occupancy.
    int          m_pos = -1;
    int          m_lvl = 0;
    logic [15:0] m_sym = '0;
    bit          m_ovf = 1'b0;
    bit          m_rse = 1'b0;
    bit          mon_en = 1'b0;
    int          out_cnt = 0;
    int          max_lvl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: everything is compared at the negedge, half a cycle from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("fifo_level", 32'(fifo_level), 32'(m_lvl));
                chk("out_valid", 32'(out_valid), 32'(m_lvl > 0));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("resync_err", 32'(resync_err), 32'(m_rse));
                chk("symbol_cnt", 32'(symbol_cnt), 32'(m_sym));
                chk("busy", 32'(busy), 32'(m_pos >= 0));
                if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got re=0x%0h with no sample expected at %0t",
                                 out_real, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("out_real", 32'(out_real), 32'(e.re));
                        chk("out_imag", 32'(out_imag), 32'(e.im));
                        chk("out_sop", 32'(out_sop), 32'(e.sop));
                        chk("out_eop", 32'(out_eop), 32'(e.eop));
                        out_cnt++;
                    end
                end
            end
        end
    end

    // One clock of stimulus; the model predicts the effect of the coming edge.
    task automatic step(input bit v, input bit s, input bit e, input bit r, input bit c,
                        input logic [DW-1:0] re, input logic [DW-1:0] im);
        bit   pop, push, set_ov, set_rs;
        int   pos_n, u;
        logic [15:0] sym_n;
        exp_t it;
        in_valid = v; sync_start = s; en = e; out_ready = r; clr_flags = c;
        in_real = re; in_imag = im;
        pop = (m_lvl > 0) && r;
        push = 1'b0; set_ov = 1'b0; set_rs = 1'b0;
        pos_n = m_pos; sym_n = m_sym;
        it = '0;
        if (m_pos >= 0 && m_pos < CP && !e) begin
            pos_n = -1;
        end else if (v) begin
            if (m_pos < 0) begin
                if (e && s) pos_n = 1;
            end else if (s) begin
                if (m_pos >= CP) set_rs = 1'b1;
                pos_n = 1;
            end else if (m_pos < CP) begin
                pos_n = m_pos + 1;
            end else begin
                u = m_pos - CP;
                push = 1'b1;
                it.sop = (u == 0); it.eop = (u == NF - 1); it.re = re; it.im = im;
                if (u == NF - 1) begin
                    sym_n = m_sym + 16'd1;
                    pos_n = e ? 0 : -1;
                end else begin
                    pos_n = m_pos + 1;
                end
            end
        end
        if (push && m_lvl == D && !pop) begin
            set_ov = 1'b1;
            push = 1'b0;
        end
        if (push) sb.push_back(it);
        @(posedge clk);
        m_pos = pos_n;
        m_sym = sym_n;
        m_lvl = m_lvl + (push ? 1 : 0) - (pop ? 1 : 0);
        m_ovf = set_ov ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_rse = set_rs ? 1'b1 : (c ? 1'b0 : m_rse);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; sync_start = 1'b0; out_ready = 1'b0;
        clr_flags = 1'b0; en = 1'b0;
        @(posedge clk);
        sb.delete();
        m_pos = -1; m_lvl = 0; m_sym = '0; m_ovf = 1'b0; m_rse = 1'b0;
        #1;
        reset = 1'b0;
        out_cnt = 0;
        max_lvl = 0;
    endtask

    task automatic drain(input bit e);
        repeat (40) step(1'b0, 1'b0, e, 1'b1, 1'b0, '0, '0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bit e;
        do_reset();
        mon_en = 1'b1;

        // Continuous ramp, two symbols.
        for (int i = 0; i < 160; i++) step(1'b1, i == 0, 1'b1, 1'b1, 1'b0, DW'(i), DW'(-i));
        drain(1'b1);
        chk("t1_symbol_cnt", 32'(symbol_cnt), 32'd2);
        chk("t1_out_cnt", 32'(out_cnt), 32'd128);
        $display("t1 continuous ramp: outputs=%0d symbols=%0d", out_cnt, symbol_cnt);

        // Same ramp with in_valid toggling.
        do_reset();
        for (int i = 0; i < 160; i++) begin
            step(1'b1, i == 0, 1'b1, 1'b1, 1'b0, DW'(i), DW'(-i));
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        end
        drain(1'b1);
        chk("t2_symbol_cnt", 32'(symbol_cnt), 32'd2);
        chk("t2_out_cnt", 32'(out_cnt), 32'd128);
        $display("t2 gapped ramp: outputs=%0d symbols=%0d", out_cnt, symbol_cnt);

        // Stalled downstream for the first symbol: FIFO fills, tail dropped.
        do_reset();
        for (int i = 0; i < 160; i++) step(1'b1, i == 0, 1'b1, i >= 80, 1'b0, DW'(i), DW'(i + 500));
        drain(1'b1);
        chk("t3_max_level", 32'(max_lvl), 32'd32);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_out_cnt", 32'(out_cnt), 32'd96);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
        chk("t3_overflow_cleared", 32'(overflow), 32'd0);
        $display("t3 overflow: outputs=%0d max_level=%0d", out_cnt, max_lvl);

        // Resync in the middle of the useful part.
        do_reset();
        for (int i = 0; i < 106; i++) step(1'b1, i == 0 || i == 26, 1'b1, 1'b1, 1'b0, DW'(i), DW'(3 * i));
        drain(1'b1);
        chk("t4_resync_err", 32'(resync_err), 32'd1);
        chk("t4_symbol_cnt", 32'(symbol_cnt), 32'd1);
        chk("t4_out_cnt", 32'(out_cnt), 32'd74);
        $display("t4 resync: outputs=%0d symbols=%0d", out_cnt, symbol_cnt);

        // Enable dropped mid-symbol: symbol finishes, then idle.
        do_reset();
        for (int i = 0; i < 140; i++) step(1'b1, i == 0, i < 46, 1'b1, 1'b0, DW'(i), DW'(i ^ 77));
        drain(1'b0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_symbol_cnt", 32'(symbol_cnt), 32'd1);
        chk("t5_out_cnt", 32'(out_cnt), 32'd64);
        $display("t5 enable drop: outputs=%0d busy=%0d", out_cnt, busy);

        // Reset with a partly full FIFO.
        do_reset();
        for (int i = 0; i < 36; i++) step(1'b1, i == 0, 1'b1, 1'b0, 1'b0, DW'(i), DW'(i));
        chk("t6_level_before", 32'(fifo_level), 32'd20);
        do_reset();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_level_after", 32'(fifo_level), 32'd0);
        chk("t6_symbol_cnt", 32'(symbol_cnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_out_real", 32'(out_real), 32'd0);
        $display("t6 reset mid-symbol: level=%0d valid=%0d", fifo_level, out_valid);

        // Randomized traffic against the model.
        do_reset();
        e = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) e = !e;
            step(($urandom % 10) < 7, $urandom_range(0, 40) == 0, e, ($urandom % 10) < 6,
                 $urandom_range(0, 99) == 0, DW'($urandom), DW'($urandom));
        end
        drain(e);
        $display("t7 random: outputs=%0d symbols=%0d", out_cnt, symbol_cnt);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ofdm_cp_remover.md
OFDM_CP_REMOVER -- requirements
Module: ofdm_cp_remover

Interface
REQ-001 Parameters SHALL be: DATA_W, default 14, sample component width; N_FFT, default 64, useful samples per symbol; CP_LEN, default 16, cyclic-prefix samples per symbol (1..N_FFT-1); FIFO_DEPTH, default 32, output buffer depth (power of 2, >=4).
REQ-002 Ports SHALL be:
  clk  in  1  single clock, all logic rising-edge;
  reset  in  1  synchronous, active-high;
  en  in  1  run enable;
  sync_start  in  1  pulse marking first CP sample of a symbol (qualified by in_valid);
  clr_flags  in  1  clears sticky flags;
  in_valid  in  1  ADC sample strobe, no backpressure;
  in_real  in  DATA_W  real sample (two's complement);
  in_imag  in  DATA_W  imaginary sample;
  out_ready  in  1  downstream accept;
  out_valid  out  1  output sample valid;
  out_real  out  DATA_W  real sample;
  out_imag  out  DATA_W  imaginary sample;
  out_sop  out  1  first useful sample of symbol;
  out_eop  out  1  last useful sample of symbol;
  symbol_cnt  out  16  completed symbols written to FIFO, wraps 0xFFFF->0;
  fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy;
  overflow  out  1  sticky, sample dropped on full FIFO;
  resync_err  out  1  sticky, sync_start during PASS;
  busy  out  1  state != IDLE.

Function
REQ-003 FSM states SHALL be IDLE, SKIP_CP, PASS; an accepted sample is a cycle with in_valid=1.
REQ-004 IDLE: stay until en=1 AND in_valid=1 AND sync_start=1; that sample SHALL be discarded as CP sample 0 and state SHALL go to SKIP_CP with cp_cnt=1 (if CP_LEN=1, directly to PASS).
REQ-005 SKIP_CP: each accepted sample SHALL be discarded and cp_cnt incremented; on the CP_LEN-th discarded sample state SHALL go to PASS with smp_cnt=0.
REQ-006 PASS: each accepted sample SHALL be pushed to the FIFO with sop=(smp_cnt==0), eop=(smp_cnt==N_FFT-1); smp_cnt increments per accepted sample.
REQ-007 After the eop sample is accepted: symbol_cnt SHALL increment; next state SKIP_CP with cp_cnt=0 if en=1, else IDLE.
REQ-008 en deasserted SHALL NOT abort a symbol in progress; IDLE is entered only at a symbol boundary or from SKIP_CP when en=0 (current CP discarded).
REQ-009 sync_start with in_valid in SKIP_CP SHALL restart CP counting (that sample = CP sample 0, cp_cnt=1), no flag.
REQ-010 sync_start with in_valid in PASS SHALL set resync_err, leave the partial symbol in the FIFO without eop, not increment symbol_cnt, and restart as in REQ-009.
REQ-011 sync_start without in_valid SHALL be ignored.
REQ-012 FIFO SHALL be first-word-fall-through: a sample written to an empty FIFO at edge t SHALL appear with out_valid=1 after edge t (latency 1 cycle).
REQ-013 Pop SHALL occur when out_valid=1 AND out_ready=1; out_* SHALL hold stable while out_valid=1 AND out_ready=0.
REQ-014 Push to a full FIFO SHALL succeed if a pop occurs the same cycle; otherwise the sample SHALL be dropped and overflow set; smp_cnt SHALL still advance (symbol timing preserved).
REQ-015 Simultaneous push and pop SHALL leave fifo_level unchanged; push into empty FIFO with out_ready=1 SHALL NOT bypass (no same-cycle output).
REQ-016 clr_flags SHALL clear overflow and resync_err one edge later; a set condition in the same cycle SHALL win.
REQ-017 Sample data SHALL pass unmodified (no scaling, rounding, or sign change).

Reset
REQ-018 reset=1 at an edge SHALL force: state IDLE, counters 0, FIFO empty, out_valid=0, out_sop=0, out_eop=0, out_real=0, out_imag=0, symbol_cnt=0, fifo_level=0, overflow=0, resync_err=0, busy=0.
REQ-019 reset mid-symbol SHALL discard FIFO contents and partial symbol; reset has priority over all inputs.

Verification
REQ-020 Defaults, en=1, out_ready=1, in_valid continuous, sync_start on sample 0 of ramp 0..159 -> outputs exactly 16..79 with sop on 16, eop on 79, then 96..159; symbol_cnt=2.
REQ-021 in_valid toggling 1/0 with the same ramp -> identical output sequence and flags; sample i first appears on out one cycle after its accepting edge.
REQ-022 out_ready=0 for a full symbol -> fifo_level reaches 32, samples 48..79 of that symbol dropped, overflow=1, next symbol's sop still at the correct sample; clr_flags -> overflow=0.
REQ-023 sync_start at PASS sample 10 -> resync_err=1, 10 samples out without eop, symbol_cnt unchanged, next 16 discarded, new sop on the 17th sample from the pulse.
REQ-024 en dropped at PASS sample 30 -> symbol completes with eop, symbol_cnt+1, busy=0 afterwards, further samples ignored.
REQ-025 reset asserted with fifo_level=20 -> next cycle out_valid=0, fifo_level=0, symbol_cnt=0, state IDLE.
